aes_key_sched: RTL and testbench
================================

# aes_key_sched

Parametrised multi-context AES key expansion engine for 128/192/256-bit keys. It expands a cipher key word by word into the full round-key schedule and stores NUM_SLOTS independent schedules, so the datapath can switch keys without re-expansion. It sits beside the cipher core and shares that core's external 32-bit S-box through the same sboxw/new_sboxw combinational handshake the key memory already uses.

## Interface
- NUM_SLOTS, 2: number of stored key schedules (1..16).
- SLOT_W, 1: slot index width, max(1, clog2(NUM_SLOTS)).
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- key  in  256  cipher key, left-aligned. 128-bit keys use [255:128]; 192-bit keys use [255:64].
- keylen  in  2  key length: 00 = 128, 01 = 192, 10 = 256, 11 = reserved.
- init  in  1  single-cycle request to expand key into init_slot.
- init_slot  in  SLOT_W  target slot for init.
- zeroize  in  1  clears all schedules and aborts any expansion.
- rd_slot  in  SLOT_W  slot to read.
- round  in  4  round index to read.
- round_key  out  128  {w[4r], w[4r+1], w[4r+2], w[4r+3]} of rd_slot; combinational.
- slot_valid  out  NUM_SLOTS  per-slot schedule-complete flags.
- ready  out  1  engine idle with its last expansion complete.
- sboxw  out  32  word to the external S-box.
- new_sboxw  in  32  S-box result for sboxw, same cycle.

## Operation
- Derived values: Nk = 4/6/8 words; Nr = 10/12/14; the schedule holds 4(Nr+1) = 44/52/60 words. Storage is NUM_SLOTS×60 words of 32 bits, plus a per-slot 2-bit keylen tag.
- States:
  - IDLE: on init, with keylen != 11 and init_slot < NUM_SLOTS, latch keylen and slot, clear ready, clear slot_valid[slot], go to LOAD. Otherwise init is ignored.
  - LOAD: write Nk key words to w[0..Nk-1], also into an 8-word sliding window. Set word counter i = Nk and rcon = 8'h01. Go to EXPAND.
  - EXPAND: generate one word per cycle, with t = w[i-1]:
    - If i mod Nk == 0: temp = RotWord(new_sboxw) ^ {rcon, 24'h0}, then rcon <= xtime(rcon) (shift left, xor 8'h1b on carry).
    - Else if Nk == 8 and i mod 8 == 4: temp = new_sboxw.
    - Else: temp = t.
    - w[i] = w[i-Nk] ^ temp. Write it to memory and the window, then i <= i+1.
    - When i == 4Nr+3 is written, go to DONE.
  - DONE: set slot_valid[slot], write the slot keylen tag, set ready, go to IDLE.
- sboxw = w[i-1] (window head) in EXPAND, 0 otherwise.
- round_key is zero if round > Nr of rd_slot's tag, or if rd_slot >= NUM_SLOTS. Otherwise it shows stored words regardless of slot_valid; a partially expanded slot reads its partial or stale content.
- init outside IDLE is ignored, with no queueing.
- zeroize, in any state: next edge clears all words, tags, and slot_valid, sets ready = 1, state = IDLE. zeroize has priority over a simultaneous init.

## Timing
- Reset values: all storage and tags 0, slot_valid 0, ready 1, state IDLE, rcon 0, i 0. round_key reads 0 after reset. sboxw is 0.
- If init is sampled at edge 0, LOAD completes at edge 1 and EXPAND runs from edge 2.
- ready and slot_valid rise after edge 42 (AES-128), 48 (AES-192) or 54 (AES-256).
- ready falls at edge 0.
- The sboxw to new_sboxw path is combinational within one cycle.
- Reads are zero-latency and may target other slots during an expansion.
- Back-to-back: init in the cycle after ready rises is accepted.
- Asynchronous reset mid-expansion returns everything to reset values immediately.

## Test plan
- AES-128 into slot 0, key 2b7e151628aed2a6abf7158809cf4f3c: ready after 42 cycles. Round 0 reads the key. Round 10 reads d014f9a8c9ee2589e13f0cc8b6630ca6. Round 11 reads 0.
- AES-192 into slot 1, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b: ready after 48 cycles. Round 12 reads e98ba06f448c773c8ecc720401002202. slot_valid = 2'b11.
- AES-256 into slot 0, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4: ready after 54 cycles. Round 1 reads 1f352c073b6108d72d9810a30914dff4. Round 14 reads fe4890d1e6188d0b046df344706c631e. Slot 1 contents are unchanged.
- init pulses at cycles 5 and 20 of an expansion, plus an init with keylen 11 while idle: all three are ignored, the schedule is correct, and the valid flags are unchanged.
- zeroize at cycle 20 of an expansion while the other slot is valid: the next cycle shows slot_valid = 0, ready = 1, all round_key reads 0, and a new init then completes normally.
- reset_n low mid-expansion: all outputs return to reset values immediately. Re-running the AES-128 vector then gives the same results.

Source files
------------

// File: rtl/aes_key_sched.sv
`timescale 1ns / 1ps
// aes_key_sched: multi-slot AES-128/192/256 key expansion, one schedule word per cycle
// through a shared external S-box; each slot keeps a complete schedule readable by round.
module aes_key_sched #(
   parameter int NUM_SLOTS = 2,
   parameter int SLOT_W    = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [255:0]         key,
   input  logic [1:0]           keylen,
   input  logic                 init,
   input  logic [SLOT_W-1:0]    init_slot,
   input  logic                 zeroize,
   input  logic [SLOT_W-1:0]    rd_slot,
   input  logic [3:0]           round,
   output logic [127:0]         round_key,
   output logic [NUM_SLOTS-1:0] slot_valid,
   output logic                 ready,
   output logic [31:0]          sboxw,
   input  logic [31:0]          new_sboxw
);

   typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

   state_t            state;
   state_t            state_next;

   logic [31:0]       mem [NUM_SLOTS][60];
   logic [1:0]        tag [NUM_SLOTS];
   logic [31:0]       win [8];
   logic [1:0]        cur_len;
   logic [SLOT_W-1:0] cur_slot;
   logic [5:0]        widx;
   logic [2:0]        phase;
   logic [7:0]        rcon;

   logic              init_ok;
   logic              load_en;
   logic              expand_en;
   logic              done_en;
   logic [2:0]        nk_m1;
   logic [5:0]        last_idx;
   logic [31:0]       temp;
   logic [31:0]       new_word;
   logic [5:0]        base;

   function automatic logic [3:0] nr_of(input logic [1:0] len);
      case (len)
         2'b00:   return 4'd10;
         2'b01:   return 4'd12;
         default: return 4'd14;
      endcase
   endfunction

   assign nk_m1    = (cur_len == 2'b00) ? 3'd3 : (cur_len == 2'b01) ? 3'd5 : 3'd7;
   assign last_idx = (cur_len == 2'b00) ? 6'd43 : (cur_len == 2'b01) ? 6'd51 : 6'd59;
   assign init_ok  = (state == IDLE) && init && !zeroize && (keylen != 2'b11)
                     && (32'(init_slot) < NUM_SLOTS);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (zeroize) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (init_ok) state_next = LOAD;
            LOAD:    state_next = EXPAND;
            EXPAND:  if (widx == last_idx) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      load_en   = 1'b0;
      expand_en = 1'b0;
      done_en   = 1'b0;
      sboxw     = '0;
      case (state)
         LOAD:   load_en = 1'b1;
         EXPAND: begin
            expand_en = 1'b1;
            sboxw     = win[0];
         end
         DONE:   done_en = 1'b1;
         default: ;
      endcase
   end

   // SubWord commutes with RotWord, so the S-box sees w[i-1] directly and the result is rotated.
   always_comb begin
      temp = win[0];
      if (phase == 3'd0)
         temp = {new_sboxw[23:0], new_sboxw[31:24]} ^ {rcon, 24'h0};
      else if (cur_len == 2'b10 && phase == 3'd4)
         temp = new_sboxw;
      new_word = win[nk_m1] ^ temp;
   end

   // win[k] holds w[i-1-k], so w[i-Nk] is always win[Nk-1].
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < NUM_SLOTS; s++) begin
            for (int w = 0; w < 60; w++) mem[s][w] <= '0;
            tag[s] <= '0;
         end
         for (int k = 0; k < 8; k++) win[k] <= '0;
         slot_valid <= '0;
         ready      <= 1'b1;
         cur_len    <= '0;
         cur_slot   <= '0;
         widx       <= '0;
         phase      <= '0;
         rcon       <= '0;
      end else if (zeroize) begin
         for (int s = 0; s < NUM_SLOTS; s++) begin
            for (int w = 0; w < 60; w++) mem[s][w] <= '0;
            tag[s] <= '0;
         end
         slot_valid <= '0;
         ready      <= 1'b1;
      end else begin
         if (init_ok) begin
            cur_len              <= keylen;
            cur_slot             <= init_slot;
            ready                <= 1'b0;
            slot_valid[init_slot] <= 1'b0;
         end
         if (load_en) begin
            for (int j = 0; j < 8; j++) begin
               if (3'(j) <= nk_m1) begin
                  mem[cur_slot][j]            <= key[255-32*j -: 32];
                  win[3'(int'(nk_m1) - j)]    <= key[255-32*j -: 32];
               end
            end
            widx  <= {3'b000, nk_m1} + 6'd1;
            phase <= 3'd0;
            rcon  <= 8'h01;
         end
         if (expand_en) begin
            mem[cur_slot][widx] <= new_word;
            win[0] <= new_word;
            for (int k = 1; k < 8; k++) win[k] <= win[k-1];
            widx  <= widx + 6'd1;
            phase <= (phase == nk_m1) ? 3'd0 : phase + 3'd1;
            if (phase == 3'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
         end
         if (done_en) begin
            slot_valid[cur_slot] <= 1'b1;
            tag[cur_slot]        <= cur_len;
            ready                <= 1'b1;
         end
      end
   end

   always_comb begin
      round_key = '0;
      base      = {round, 2'b00};
      if ((32'(rd_slot) < NUM_SLOTS) && (round <= nr_of(tag[rd_slot])))
         round_key = {mem[rd_slot][base],         mem[rd_slot][base + 6'd1],
                      mem[rd_slot][base + 6'd2], mem[rd_slot][base + 6'd3]};
   end

endmodule

// File: tb/tb_aes_key_sched.sv
`timescale 1ns / 1ps
// tb_aes_key_sched: FIPS-197 vectors, random expansions against a textbook key-expansion
// model, and the ignored-init, zeroize and mid-expansion reset sequences.
module tb_aes_key_sched;

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic [255:0] key = '0;
   logic [1:0]   keylen = '0;
   logic         init = 1'b0;
   logic [0:0]   init_slot = '0;
   logic         zeroize = 1'b0;
   logic [0:0]   rd_slot = '0;
   logic [3:0]   round = '0;
   logic [127:0] round_key;
   logic [1:0]   slot_valid;
   logic         ready;
   logic [31:0]  sboxw;
   logic [31:0]  new_sboxw;

   logic [7:0]   sbox [256];
   logic [31:0]  exp_w [2][60];
   logic [1:0]   exp_tag [2];
   logic [1:0]   exp_valid;
   int           checks = 0;
   int           errors = 0;

   typedef struct {
      logic [0:0]   slot;
      logic [1:0]   len;
      logic [255:0] k;
      int           edges;
      logic [1:0]   valid;
      logic [3:0]   r0, r1, r2;
      logic [127:0] rk0, rk1, rk2;
   } vec_t;

   vec_t vecs [3];

   aes_key_sched #(.NUM_SLOTS(2), .SLOT_W(1)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .key        (key),
      .keylen     (keylen),
      .init       (init),
      .init_slot  (init_slot),
      .zeroize    (zeroize),
      .rd_slot    (rd_slot),
      .round      (round),
      .round_key  (round_key),
      .slot_valid (slot_valid),
      .ready      (ready),
      .sboxw      (sboxw),
      .new_sboxw  (new_sboxw)
   );

   always #5 clk = ~clk;

   assign new_sboxw = {sbox[sboxw[31:24]], sbox[sboxw[23:16]], sbox[sboxw[15:8]], sbox[sboxw[7:0]]};

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] simulation did not finish");
   end

   function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = '0;
      for (int k = 0; k < 8; k++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
         b = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [15:0] d;
      d = {v, v} << n;
      return d[15:8];
   endfunction

   // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] t);
      return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
   endfunction

   function automatic int nk_of(input logic [1:0] len);
      return (len == 2'b00) ? 4 : (len == 2'b01) ? 6 : 8;
   endfunction

   task automatic model_clear();
      for (int s = 0; s < 2; s++) begin
         for (int w = 0; w < 60; w++) exp_w[s][w] = '0;
         exp_tag[s] = '0;
      end
      exp_valid = '0;
   endtask

   task automatic model_expand(input int slot, input logic [1:0] len, input logic [255:0] k);
      int          nk, total;
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      nk    = nk_of(len);
      total = 4 * (nk + 7);
      for (int j = 0; j < nk; j++) w[j] = k[255-32*j -: 32];
      rc = 8'h01;
      for (int i = nk; i < total; i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end else if (nk == 8 && i % nk == 4) begin
            t = sub_word(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int i = 0; i < total; i++) exp_w[slot][i] = w[i];
      exp_tag[slot]   = len;
      exp_valid[slot] = 1'b1;
   endtask

   function automatic logic [127:0] exp_read(input int s, input int r);
      int nr;
      nr = nk_of(exp_tag[s]) + 6;
      if (r > nr) return '0;
      return {exp_w[s][4*r], exp_w[s][4*r+1], exp_w[s][4*r+2], exp_w[s][4*r+3]};
   endfunction

   function automatic logic [255:0] rand_key();
      logic [255:0] k;
      for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom();
      return k;
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s got %h want %h", name, got, want);
      end
   endtask

   // Drives a one-cycle init so it is sampled at the next edge (edge 0 of the expansion).
   task automatic applyStimulus(input logic [0:0] s, input logic [1:0] len, input logic [255:0] k);
      key       = k;
      keylen    = len;
      init_slot = s;
      init      = 1'b1;
      @(posedge clk);
      #1;
      init = 1'b0;
      exp_valid[s] = 1'b0;
      checkOutput("ready falls at edge 0", 128'(ready), 128'(0));
      checkOutput("slot_valid cleared on init", 128'(slot_valid), 128'(exp_valid));
   endtask

   task automatic wait_ready(input int start, input int peek_slot, output int n);
      n = start;
      while (!ready && n < 200) begin
         @(posedge clk);
         #1;
         n++;
         if (peek_slot >= 0 && n == 10) begin
            rd_slot = 1'(peek_slot);
            round   = 4'($urandom_range(0, 15));
            #1;
            checkOutput("read other slot mid-expansion", round_key, exp_read(peek_slot, int'(round)));
         end
      end
   endtask

   task automatic sweep(input string tag);
      for (int s = 0; s < 2; s++) begin
         for (int r = 0; r < 16; r++) begin
            rd_slot = 1'(s);
            round   = 4'(r);
            @(negedge clk);
            checkOutput($sformatf("%s slot%0d round%0d", tag, s, r), round_key, exp_read(s, r));
         end
      end
   endtask

   task automatic run_vector(input vec_t v);
      int n, nk;
      nk = nk_of(v.len);
      applyStimulus(v.slot, v.len, v.k);
      @(posedge clk);
      #1;
      checkOutput("sboxw is w[Nk-1] after load", 128'(sboxw), 128'(v.k[255-32*(nk-1) -: 32]));
      wait_ready(1, -1, n);
      checkOutput("vector expansion edges", 128'(n), 128'(v.edges));
      model_expand(int'(v.slot), v.len, v.k);
      checkOutput("vector slot_valid", 128'(slot_valid), 128'(v.valid));
      checkOutput("sboxw idle", 128'(sboxw), 128'(0));
      rd_slot = v.slot;
      round   = v.r0;
      @(negedge clk);
      checkOutput("vector read a", round_key, v.rk0);
      round = v.r1;
      @(negedge clk);
      checkOutput("vector read b", round_key, v.rk1);
      round = v.r2;
      @(negedge clk);
      checkOutput("vector read c", round_key, v.rk2);
   endtask

   initial begin
      int          n, s, nk;
      logic [1:0]  len;
      logic [255:0] k;

      vecs[0] = '{slot: 1'b0, len: 2'b00,
                  k: {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                  edges: 42, valid: 2'b01, r0: 4'd0, r1: 4'd10, r2: 4'd11,
                  rk0: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                  rk1: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                  rk2: 128'h0};
      vecs[1] = '{slot: 1'b1, len: 2'b01,
                  k: {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0},
                  edges: 48, valid: 2'b11, r0: 4'd12, r1: 4'd0, r2: 4'd13,
                  rk0: 128'he98ba06f448c773c8ecc720401002202,
                  rk1: 128'h8e73b0f7da0e6452c810f32b809079e5,
                  rk2: 128'h0};
      vecs[2] = '{slot: 1'b0, len: 2'b10,
                  k: 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                  edges: 54, valid: 2'b11, r0: 4'd1, r1: 4'd14, r2: 4'd0,
                  rk0: 128'h1f352c073b6108d72d9810a30914dff4,
                  rk1: 128'hfe4890d1e6188d0b046df344706c631e,
                  rk2: 128'h603deb1015ca71be2b73aef0857d7781};

      build_sbox();
      model_clear();

      #2 reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset ready", 128'(ready), 128'(1));
      checkOutput("reset slot_valid", 128'(slot_valid), 128'(0));
      checkOutput("reset sboxw", 128'(sboxw), 128'(0));
      @(negedge clk);
      reset_n = 1'b1;
      sweep("after reset");

      for (int v = 0; v < 3; v++) run_vector(vecs[v]);
      sweep("fips vectors");

      // Init pulses at edges 5 and 20 of a running expansion, then a reserved keylen while idle.
      k = rand_key();
      applyStimulus(1'b1, 2'b00, k);
      n = 0;
      while (!ready && n < 200) begin
         if (n == 4 || n == 19) begin
            init      = 1'b1;
            init_slot = 1'b0;
            keylen    = 2'b10;
            key       = rand_key();
         end
         @(posedge clk);
         #1;
         init = 1'b0;
         n++;
      end
      checkOutput("ignored-init edges", 128'(n), 128'(42));
      model_expand(1, 2'b00, k);
      checkOutput("ignored-init slot_valid", 128'(slot_valid), 128'(exp_valid));
      init      = 1'b1;
      init_slot = 1'b0;
      keylen    = 2'b11;
      @(posedge clk);
      #1;
      init = 1'b0;
      checkOutput("reserved keylen keeps ready", 128'(ready), 128'(1));
      checkOutput("reserved keylen keeps valid", 128'(slot_valid), 128'(2'b11));
      @(posedge clk);
      #1;
      checkOutput("reserved keylen sboxw idle", 128'(sboxw), 128'(0));
      sweep("ignored init");

      // Random expansions, two back to back per pass, reading the other slot mid-flight.
      for (int it = 0; it < 4; it++) begin
         for (int b = 0; b < 2; b++) begin
            s   = $urandom_range(0, 1);
            len = 2'($urandom_range(0, 2));
            k   = rand_key();
            nk  = nk_of(len);
            applyStimulus(1'(s), len, k);
            wait_ready(0, 1 - s, n);
            checkOutput("random expansion edges", 128'(n), 128'(4 * (nk + 7) - nk + 2));
            model_expand(s, len, k);
            checkOutput("random slot_valid", 128'(slot_valid), 128'(exp_valid));
         end
         sweep("random");
      end

      // Zeroize sampled at edge 20 of an expansion.
      applyStimulus(1'b0, 2'b00, rand_key());
      repeat (19) @(posedge clk);
      #1;
      zeroize = 1'b1;
      @(posedge clk);
      #1;
      zeroize = 1'b0;
      model_clear();
      checkOutput("zeroize slot_valid", 128'(slot_valid), 128'(0));
      checkOutput("zeroize ready", 128'(ready), 128'(1));
      checkOutput("zeroize sboxw", 128'(sboxw), 128'(0));
      sweep("zeroize");
      k = rand_key();
      applyStimulus(1'b1, 2'b10, k);
      wait_ready(0, 0, n);
      checkOutput("post-zeroize edges", 128'(n), 128'(54));
      model_expand(1, 2'b10, k);
      checkOutput("post-zeroize slot_valid", 128'(slot_valid), 128'(exp_valid));
      sweep("post zeroize");

      // Asynchronous reset in the middle of an expansion.
      applyStimulus(1'b0, 2'b00, vecs[0].k);
      repeat (15) @(posedge clk);
      #3;
      reset_n = 1'b0;
      rd_slot = 1'b1;
      round   = 4'd3;
      #1;
      checkOutput("async reset ready", 128'(ready), 128'(1));
      checkOutput("async reset slot_valid", 128'(slot_valid), 128'(0));
      checkOutput("async reset sboxw", 128'(sboxw), 128'(0));
      checkOutput("async reset round_key", round_key, 128'(0));
      model_clear();
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run_vector(vecs[0]);
      sweep("after async reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
